// File: rtl/fft_input_loader.sv
// fft_input_loader
// Feeds one frame of NUMSAMPLES time-domain samples from a valid/ready
// stream into the four RAM banks of the fft core, in natural or
// bit-reversed order, and answers the core's ld_data request with ld_done.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   ld_data      load request from the fft core (level)
//   ld_done      frame fully committed to the banks (held while ld_data high)
//   in_valid     upstream sample valid
//   in_data      upstream sample
//   in_ready     loader accepts a sample this cycle
//   bank_wr_en   one-hot bank write enable
//   bank_wr_addr write address shared by all banks
//   bank_wr_data write data broadcast to all banks
//   busy         loading or flushing the final write
//   sample_cnt   samples accepted in the current frame
module fft_input_loader #(
    parameter int WORDSIZE   = 16,
    parameter int ADDRSIZE   = 3,
    parameter int NUMSAMPLES = 32,
    parameter int BITREV     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_data,
    output logic                  ld_done,
    input  logic                  in_valid,
    input  logic [WORDSIZE-1:0]   in_data,
    output logic                  in_ready,
    output logic [3:0]            bank_wr_en,
    output logic [ADDRSIZE-1:0]   bank_wr_addr,
    output logic [WORDSIZE-1:0]   bank_wr_data,
    output logic                  busy,
    output logic [ADDRSIZE+1:0]   sample_cnt
);

    localparam int CW = ADDRSIZE + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       sample_cnt_r;
    logic [CW-1:0]       sample_cnt_s;
    logic                accept_s;
    logic [CW-1:0]       map_s;
    logic [3:0]          wr_en_r;
    logic [ADDRSIZE-1:0] wr_addr_r;
    logic [WORDSIZE-1:0] wr_data_r;

    function automatic logic [CW-1:0] bit_reverse(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[CW-1-i];
        end
        return r;
    endfunction

    assign accept_s = in_valid && (state_r == S_LOAD);

    // The current count is the index of the sample being accepted.
    assign map_s = (BITREV != 0) ? bit_reverse(sample_cnt_r) : sample_cnt_r;

    // Next-state and sample counter logic.
    always_comb begin
        state_s      = state_r;
        sample_cnt_s = sample_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (ld_data) begin
                    state_s      = S_LOAD;
                    sample_cnt_s = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // ld_data is deliberately ignored here: a started frame always completes.
                if (accept_s) begin
                    sample_cnt_s = sample_cnt_r + CW'(1);
                    if (sample_cnt_r == CW'(NUMSAMPLES - 1)) begin
                        state_s = S_FLUSH;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_FLUSH: begin
                state_s = S_DONE;
            end
            S_DONE: begin
                if (!ld_data) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s      = S_IDLE;
                sample_cnt_s = '0;
            end
        endcase
    end

    // State and sample counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            sample_cnt_r <= '0;
        end else begin
            state_r      <= state_s;
            sample_cnt_r <= sample_cnt_s;
        end
    end

    // One-cycle write stage; address and data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 4'b0000;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else if (accept_s) begin
            wr_en_r   <= 4'b0001 << map_s[1:0];
            wr_addr_r <= map_s[CW-1:2];
            wr_data_r <= in_data;
        end else begin
            wr_en_r <= 4'b0000;
        end
    end

    // Status outputs decode directly from the state register, so ld_done
    // rises only in the cycle after the FLUSH write has committed.
    assign in_ready     = (state_r == S_LOAD);
    assign busy         = (state_r == S_LOAD) || (state_r == S_FLUSH);
    assign ld_done      = (state_r == S_DONE);
    assign sample_cnt   = sample_cnt_r;
    assign bank_wr_en   = wr_en_r;
    assign bank_wr_addr = wr_addr_r;
    assign bank_wr_data = wr_data_r;

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

    localparam int W = 16;
    localparam int A = 3;
    localparam int N = 32;

    typedef logic [4+A+W-1:0] wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, ld_data, in_valid;
    logic [W-1:0] in_data;

    logic         ld_done0, in_ready0, busy0;
    logic [3:0]   en0;
    logic [A-1:0] addr0;
    logic [W-1:0] data0;
    logic [A+1:0] cnt0;

    logic         ld_done1, in_ready1, busy1;
    logic [3:0]   en1;
    logic [A-1:0] addr1;
    logic [W-1:0] data1;
    logic [A+1:0] cnt1;

    int checks = 0;
    int errors = 0;

    wr_t q0[$];
    wr_t q1[$];
    logic [N-1:0] seen0, seen1;

    // hand-computed 5-bit bit-reversal table
    int rev_tab [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                         1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    fft_input_loader #(.WORDSIZE(W), .ADDRSIZE(A), .NUMSAMPLES(N), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .ld_data(ld_data), .ld_done(ld_done0),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .bank_wr_en(en0), .bank_wr_addr(addr0), .bank_wr_data(data0),
        .busy(busy0), .sample_cnt(cnt0)
    );

    fft_input_loader #(.WORDSIZE(W), .ADDRSIZE(A), .NUMSAMPLES(N), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .ld_data(ld_data), .ld_done(ld_done1),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .bank_wr_en(en1), .bank_wr_addr(addr1), .bank_wr_data(data1),
        .busy(busy1), .sample_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t exp_wr(input int n, input logic [W-1:0] d, input bit rev);
        int r;
        r = rev ? rev_tab[n] : n;
        return {4'(1 << (r % 4)), 3'(r / 4), d};
    endfunction

    function automatic int bank_idx(input logic [3:0] en);
        case (en)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    // monitor: every write pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        wr_t e;
        int  p;
        if (en0 !== 4'b0000) begin
            if (q0.size() == 0) begin
                chk("unexpected_wr_nat", {28'd0, en0}, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("wr_nat", {9'd0, en0, addr0, data0}, {9'd0, e});
                p = int'(addr0) * 4 + bank_idx(en0);
                chk("dup_nat", {31'd0, seen0[p]}, 32'd0);
                seen0[p] = 1'b1;
            end
        end
        if (en1 !== 4'b0000) begin
            if (q1.size() == 0) begin
                chk("unexpected_wr_rev", {28'd0, en1}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("wr_rev", {9'd0, en1, addr1, data1}, {9'd0, e});
                p = int'(addr1) * 4 + bank_idx(en1);
                chk("dup_rev", {31'd0, seen1[p]}, 32'd0);
                seen1[p] = 1'b1;
            end
        end
    end

    task automatic reset_checks();
        chk("rst_cnt", {27'd0, cnt0}, 32'd0);
        chk("rst_cnt_rev", {27'd0, cnt1}, 32'd0);
        chk("rst_ld_done", {31'd0, ld_done0}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_wr_en", {28'd0, en0}, 32'd0);
        chk("rst_wr_en_rev", {28'd0, en1}, 32'd0);
        chk("rst_wr_addr", {29'd0, addr0}, 32'd0);
        chk("rst_wr_data", {16'd0, data0}, 32'd0);
        chk("rst_wr_data_rev", {16'd0, data1}, 32'd0);
    endtask

    // One frame; called and returning on a negedge.
    task automatic frame(input logic [W-1:0] base, input bit stall, input int drop_at,
                         input int abort_at, input int hold);
        int n = 0;
        int cyc = 0;
        int k = 0;
        bit done = 1'b0;
        seen0 = '0;
        seen1 = '0;
        ld_data = 1'b1;
        in_valid = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chk("sample_cnt", {27'd0, cnt0}, 32'(n % N));
            chk("sample_cnt_rev", {27'd0, cnt1}, 32'(n % N));
            if (abort_at >= 0 && n == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                ld_data = 1'b0;
                @(negedge clk);
                reset_checks();
                rst = 1'b0;
                repeat (4) @(negedge clk);
                chk("abort_no_writes", 32'(q0.size() + q1.size()), 32'd0);
                return;
            end
            if (ld_done0) begin
                done = 1'b1;
            end else begin
                if (drop_at >= 0 && n >= drop_at) ld_data = 1'b0;
                in_valid = (n < N) && (!stall || (k % 4 == 0) || (k % 4 == 3));
                k++;
                in_data = base + W'(n);
                if (in_valid && in_ready0 && !rst) begin
                    q0.push_back(exp_wr(n, in_data, 1'b0));
                    q1.push_back(exp_wr(n, in_data, 1'b1));
                    n++;
                end
            end
        end
        chk("ld_done_seen", {31'd0, done}, 32'd1);
        if (!stall) chk("ld_latency", 32'(cyc), 32'd34);
        chk("ld_done_rev", {31'd0, ld_done1}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("done_busy", {31'd0, busy0}, 32'd0);
        chk("pending_writes", 32'(q0.size() + q1.size()), 32'd0);
        chk("cover_nat", seen0, 32'hFFFF_FFFF);
        chk("cover_rev", seen1, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_ld_done", {31'd0, ld_done0}, 32'd1);
                chk("hold_in_ready", {31'd0, in_ready0}, 32'd0);
            end
            in_valid = 1'b0;
        end
        ld_data = 1'b0;
        @(negedge clk);
        chk("ld_done_clear", {31'd0, ld_done0}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready0}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ld_data = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset_checks();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, in_ready0}, 32'd0);

        frame(16'h0000, 1'b0, -1, -1, 0);   // natural/bit-reversed, unstalled
        frame(16'h0000, 1'b1, -1, -1, 0);   // stalled upstream, same data
        frame(16'h0300, 1'b0, -1, -1, 10);  // ld_data held after ld_done
        frame(16'h0400, 1'b0, -1, -1, 0);   // second frame after hold
        frame(16'h0500, 1'b0, -1, 13, 0);   // reset after 13 samples
        frame(16'h0600, 1'b0, -1, -1, 0);   // fresh frame after reset
        frame(16'h0700, 1'b0, 20, -1, 0);   // early ld_data drop

        repeat (5) @(negedge clk);
        chk("final_idle_busy", {31'd0, busy0}, 32'd0);
        chk("final_queues", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream feeder for the fft core. Accepts a stream of NUMSAMPLES time-domain samples over a valid/ready handshake and writes them into the core's four RAM banks.
- Writes use natural or bit-reversed ordering, so stage 0 can start directly on the loaded data.
- Answers the core's ld_data request with ld_done once the last bank write has committed.

Parameters:
- WORDSIZE, 16, sample/bank word width
- ADDRSIZE, 3, per-bank address width; ADDRSIZE+2 must equal log2(NUMSAMPLES)
- NUMSAMPLES, 32, samples per frame; 4 banks of NUMSAMPLES/4 words
- BITREV, 1, 1 = bank index derived from bit-reversed sample index; 0 = natural order

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ld_data  in  1  load request from fft core, level; held until ld_done seen
- ld_done  out  1  frame fully written to banks; held while ld_data stays high
- in_valid  in  1  upstream sample valid
- in_data  in  WORDSIZE  upstream sample
- in_ready  out  1  loader can accept a sample this cycle
- bank_wr_en  out  4  one-hot bank write enable (bit k drives wr_en/cs of bank k)
- bank_wr_addr  out  ADDRSIZE  write address, common to all banks
- bank_wr_data  out  WORDSIZE  write data, broadcast to all bank data_in
- busy  out  1  high in LOAD or FLUSH
- sample_cnt  out  ADDRSIZE+2  samples accepted in current frame

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; sample_cnt=0; ld_done=0; in_ready=0; busy=0.
  - bank_wr_en=0; bank_wr_addr=0; bank_wr_data=0.
  - rst wins over every other input.
  - Mid-frame reset aborts the frame: no further writes; already-written bank words are left as-is.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - in_ready=0, no writes.
  - ld_data=1 -> LOAD; sample_cnt cleared to 0.
- LOAD:
  - in_ready=1 (combinational from state).
  - Accept = in_valid & in_ready.
  - Each accept increments sample_cnt and registers one bank write for the next cycle.
  - Accept with sample_cnt==NUMSAMPLES-1 -> FLUSH; sample_cnt wraps to 0.
  - ld_data deasserting during LOAD is ignored; the frame always completes.
- Address mapping for the accepted sample index n (ADDRSIZE+2 bits):
  - r = BITREV ? bit_reverse(n) : n.
  - Target bank = r[1:0]; bank_wr_addr = r[ADDRSIZE+1:2].
- Write timing:
  - Write latency is 1 cycle: a sample accepted in cycle t appears on bank_wr_en/addr/data in cycle t+1.
  - Exactly one bank_wr_en bit is high during a write cycle; all bits are 0 otherwise.
  - bank_wr_addr and bank_wr_data hold their last values when no write occurs.
  - Back-to-back accepts produce back-to-back writes, one per cycle, no bubbles.
- FLUSH:
  - Cycle carrying the final write; in_ready=0.
  - Unconditional -> DONE.
- DONE:
  - ld_done=1, in_ready=0, no writes.
  - ld_done first rises the cycle after the final write, so the core sees it only after all data has committed.
  - ld_data=0 -> IDLE, with ld_done=0 the cycle after the transition.
  - If ld_data stays high, remain in DONE; a new frame is never started without a 0->1 re-request through IDLE.
- in_valid while in_ready=0 is not consumed; upstream must hold in_data stable until accepted.
- Throughput: NUMSAMPLES+2 cycles from ld_data rise to ld_done with in_valid held high.

Test Plan:
- Natural load, BITREV=0, in_data=n for n=0..31, in_valid held high -> writes in order: bank n%4, addr n/4, data n; ld_done rises exactly 34 cycles after ld_data rise.
- Bit-reversed load, BITREV=1:
  - n=1 -> bank0 addr4; n=3 -> bank0 addr6.
  - n=5 -> bank0 addr5; n=8 -> bank2 addr0.
  - n=31 -> bank3 addr7.
  - Scoreboard confirms every (bank,addr) pair is written exactly once per frame.
- Stalled upstream: in_valid toggled 1,0,0,1 pattern -> sample_cnt advances only on accepts; no bank_wr_en pulse in cycles after a non-accept; final data is identical to the unstalled run.
- Handshake hold: keep ld_data=1 for 10 cycles after ld_done -> ld_done stays 1, in_ready stays 0, no writes. Then drop ld_data -> IDLE, ld_done=0 next cycle; second frame loads correctly.
- Reset after 13 samples -> all outputs at reset values next cycle; no writes follow; a fresh ld_data completes a full 32-sample frame with sample_cnt starting at 0.
- Early ld_data drop during LOAD at sample 20 -> load continues to 32 samples, ld_done pulses, then returns to IDLE.
